// File: rtl/spi_xfer_buffer_if.sv
// Host and SPI-master side signals of spi_xfer_buffer, bundled with DUT/driver modports.
interface spi_xfer_buffer_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  m_data_in;
  logic        m_en;
  logic        m_busy;
  logic [7:0]  m_data_out;
  logic [AW:0] tx_count;
  logic [AW:0] rx_count;
  logic        err_timeout;
  logic        clr_err;

  modport slave (
    input  tx_data, tx_valid, rx_ready, m_busy, m_data_out, clr_err,
    output tx_ready, rx_data, rx_valid, m_data_in, m_en, tx_count, rx_count, err_timeout
  );

  modport master (
    output tx_data, tx_valid, rx_ready, m_busy, m_data_out, clr_err,
    input  tx_ready, rx_data, rx_valid, m_data_in, m_en, tx_count, rx_count, err_timeout
  );
endinterface

// File: rtl/spi_xfer_buffer.sv
// Buffered byte controller between host logic and an SPI master: TX FIFO -> master -> RX FIFO,
// with a sticky timeout flag when the master never reports busy.
module spi_xfer_buffer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  spi_xfer_buffer_if.slave bus
);
  localparam logic [AW:0] FullCnt    = (AW+1)'(DEPTH);
  localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLoad     = 3'd1,
    StStart    = 3'd2,
    StWaitBusy = 3'd3,
    StXfer     = 3'd4,
    StCapture  = 3'd5
  } state_e;

  state_e r_state, w_state_next;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [AW:0]   r_tx_cnt, r_rx_cnt;
  logic [7:0]    r_to_cnt;
  logic [7:0]    r_m_data_in;
  logic          r_m_en;
  logic          r_err;

  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_en_set, w_to_clr, w_to_inc, w_to_fire, w_late;

  assign w_tx_push = bus.tx_valid && (r_tx_cnt != FullCnt);
  assign w_rx_pop  = bus.rx_ready && (r_rx_cnt != '0);
  assign w_late    = (r_to_cnt >= TimeoutCnt);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Entering LOAD only with RX space free reserves the slot the capture will use.
  always_comb begin
    w_state_next = StIdle;
    case (r_state)
      StIdle:     w_state_next = (r_tx_cnt != '0 && r_rx_cnt != FullCnt) ? StLoad : StIdle;
      StLoad:     w_state_next = StStart;
      StStart:    w_state_next = StWaitBusy;
      StWaitBusy: begin
        if (bus.m_busy) w_state_next = StXfer;
        else if (w_late) w_state_next = StIdle;
        else w_state_next = StWaitBusy;
      end
      StXfer:     w_state_next = bus.m_busy ? StXfer : StCapture;
      StCapture:  w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_tx_pop  = 1'b0;
    w_rx_push = 1'b0;
    w_en_set  = 1'b0;
    w_to_clr  = 1'b0;
    w_to_inc  = 1'b0;
    w_to_fire = 1'b0;
    case (r_state)
      StLoad:     w_tx_pop = 1'b1;
      StStart:    begin
        w_en_set = 1'b1;
        w_to_clr = 1'b1;
      end
      StWaitBusy: begin
        if (!bus.m_busy) begin
          w_to_fire = w_late;
          w_to_inc  = !w_late;
        end
      end
      StCapture:  w_rx_push = 1'b1;
      default:    ;
    endcase
  end

  // Storage is not reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus.tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.m_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_tx_cnt    <= '0;
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_rx_cnt    <= '0;
      r_to_cnt    <= '0;
      r_m_data_in <= '0;
      r_m_en      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: ;
      endcase

      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: ;
      endcase

      if (w_tx_pop) r_m_data_in <= r_tx_mem[r_tx_rd];

      if (w_en_set) r_m_en <= 1'b1;
      else if (w_rx_push || w_to_fire) r_m_en <= 1'b0;

      if (w_to_clr) r_to_cnt <= '0;
      else if (w_to_inc) r_to_cnt <= r_to_cnt + 8'd1;

      // A timeout in the same cycle as clr_err keeps the flag set.
      if (w_to_fire) r_err <= 1'b1;
      else if (bus.clr_err) r_err <= 1'b0;
    end
  end

  assign bus.tx_ready    = (r_tx_cnt != FullCnt);
  assign bus.rx_valid    = (r_rx_cnt != '0);
  assign bus.rx_data     = r_rx_mem[r_rx_rd];
  assign bus.m_data_in   = r_m_data_in;
  assign bus.m_en        = r_m_en;
  assign bus.tx_count    = r_tx_cnt;
  assign bus.rx_count    = r_rx_cnt;
  assign bus.err_timeout = r_err;
endmodule
